cyc_12_alpha_decoder: RTL and testbench

CYC_12_ALPHA_DECODER -- requirements
Module: cyc_12_alpha_decoder

---
 rtl/cyc_12_alpha_decoder.sv | 146 ++++++++++++++
 tb/tb_cyc_12_alpha_decoder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cyc_12_alpha_decoder.sv
// PUCCH format-0 cyclic-shift decoder: peak search over 12 shift metrics, then mcs/HARQ-ACK recovery.
// Optional DTX detection is enabled by defining CYC12_DTX_DETECT_EN.
module cyc_12_alpha_decoder #(
  parameter int METRIC_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic [4:0]          i_base_alpha,
  input  logic [1:0]          i_nbits,
  input  logic                i_metric_valid,
  input  logic [METRIC_W-1:0] i_metric,
  input  logic [METRIC_W-1:0] i_dtx_threshold,
  output logic                o_ready,
  output logic                o_valid,
  output logic [3:0]          o_mcs,
  output logic [1:0]          o_harq,
  output logic [METRIC_W-1:0] o_peak,
  output logic                o_err,
  output logic                o_dtx
);

  // state   | meaning
  // IDLE    | waiting for i_start
  // COLLECT | accepting metrics k=0..11, tracking the peak
  // RESOLVE | peak index -> mcs -> HARQ bits, results registered
  // DONE    | o_valid strobe, then back to IDLE
  typedef enum logic [1:0] {IDLE, COLLECT, RESOLVE, DONE} state_t;

  state_t              state_q, state_d;
  logic [4:0]          base_q;
  logic [1:0]          nbits_q;
  logic [3:0]          cnt_q;
  logic [3:0]          pk_idx_q;
  logic [METRIC_W-1:0] peak_q;
  logic                accept;
  logic                cfg_bad;
  logic [4:0]          k_pk;
  logic [4:0]          mcs;
  logic [1:0]          harq;
  logic                err;
  logic                dtx;

  assign o_ready = (state_q == COLLECT);
  assign o_valid = (state_q == DONE);
  assign accept  = o_ready & i_metric_valid & ~i_start;

  always_comb begin
    state_d = state_q;
    if (i_start) begin
      state_d = COLLECT;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        COLLECT: if (accept && cnt_q == 4'd11) state_d = RESOLVE;
        RESOLVE: state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q   <= '0;
      nbits_q  <= '0;
      cnt_q    <= '0;
      pk_idx_q <= '0;
      peak_q   <= '0;
    end else if (i_start) begin
      base_q   <= i_base_alpha;
      nbits_q  <= i_nbits;
      cnt_q    <= '0;
      pk_idx_q <= '0;
      peak_q   <= '0;
    end else if (accept) begin
      // first metric always loads so an all-zero symbol still has a defined peak
      if (cnt_q == 4'd0 || i_metric > peak_q) begin
        peak_q   <= i_metric;
        pk_idx_q <= cnt_q;
      end
      cnt_q <= (cnt_q == 4'd11) ? 4'd0 : cnt_q + 4'd1;
    end
  end

  assign k_pk    = {1'b0, pk_idx_q};
  assign mcs     = (k_pk >= base_q) ? (k_pk - base_q) : (k_pk + 5'd12 - base_q);
  assign cfg_bad = (base_q > 5'd11) || !(nbits_q == 2'd1 || nbits_q == 2'd2);

`ifdef CYC12_DTX_DETECT_EN
  assign dtx = (peak_q < i_dtx_threshold);
`else
  logic unused_dtx_threshold;
  assign unused_dtx_threshold = ^i_dtx_threshold;
  assign dtx = 1'b0;
`endif

  always_comb begin
    harq = 2'b00;
    err  = 1'b0;
    if (cfg_bad) begin
      err = 1'b1;
    end else if (nbits_q == 2'd1) begin
      case (mcs)
        5'd0:    harq = 2'b00;
        5'd6:    harq = 2'b01;
        default: err  = 1'b1;
      endcase
    end else begin
      case (mcs)
        5'd0:    harq = 2'b00;
        5'd3:    harq = 2'b01;
        5'd6:    harq = 2'b11;
        5'd9:    harq = 2'b10;
        default: err  = 1'b1;
      endcase
    end
    // no transmission detected: nothing to decode, so no error either
    if (dtx) begin
      harq = 2'b00;
      err  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_mcs  <= '0;
      o_harq <= '0;
      o_peak <= '0;
      o_err  <= 1'b0;
      o_dtx  <= 1'b0;
    end else if (state_q == RESOLVE && !i_start) begin
      o_mcs  <= mcs[3:0];
      o_harq <= harq;
      o_peak <= peak_q;
      o_err  <= err;
      o_dtx  <= dtx;
    end
  end

endmodule

// File: tb/tb_cyc_12_alpha_decoder.sv
// Directed scoreboard bench for cyc_12_alpha_decoder; honours CYC12_DTX_DETECT_EN in its model.
module tb_cyc_12_alpha_decoder;
  localparam int W = 16;

  logic          clk;
  logic          rst_n;
  logic          i_start;
  logic [4:0]    i_base_alpha;
  logic [1:0]    i_nbits;
  logic          i_metric_valid;
  logic [W-1:0]  i_metric;
  logic [W-1:0]  i_dtx_threshold;
  logic          o_ready;
  logic          o_valid;
  logic [3:0]    o_mcs;
  logic [1:0]    o_harq;
  logic [W-1:0]  o_peak;
  logic          o_err;
  logic          o_dtx;

  cyc_12_alpha_decoder #(.METRIC_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_base_alpha(i_base_alpha),
    .i_nbits(i_nbits), .i_metric_valid(i_metric_valid), .i_metric(i_metric),
    .i_dtx_threshold(i_dtx_threshold), .o_ready(o_ready), .o_valid(o_valid),
    .o_mcs(o_mcs), .o_harq(o_harq), .o_peak(o_peak), .o_err(o_err), .o_dtx(o_dtx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   mcs;
    logic [1:0]   harq;
    logic [W-1:0] peak;
    logic         err;
    logic         dtx;
    bit           chk_mcs;
  } exp_t;

  exp_t        sb[$];
  int          total   = 0;
  int          bad     = 0;
  int          n_valid = 0;
  int          n_push  = 0;
  int unsigned m[12];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int base, input int nbits, input int unsigned thr);
    exp_t        e;
    int          pk_i;
    int unsigned pk;
    int          mc;
    pk_i = 0;
    pk   = m[0];
    for (int k = 1; k < 12; k++)
      if (m[k] > pk) begin pk = m[k]; pk_i = k; end
    e.peak    = pk[W-1:0];
    e.chk_mcs = (base <= 11);
    mc        = (pk_i - base + 12) % 12;
    e.mcs     = mc[3:0];
    e.harq    = 2'b00;
    e.err     = 1'b0;
    e.dtx     = 1'b0;
    if (base > 11 || (nbits != 1 && nbits != 2)) e.err = 1'b1;
    else if (nbits == 1) begin
      if (mc == 6) e.harq = 2'b01;
      else if (mc != 0) e.err = 1'b1;
    end else begin
      if (mc == 3) e.harq = 2'b01;
      else if (mc == 6) e.harq = 2'b11;
      else if (mc == 9) e.harq = 2'b10;
      else if (mc != 0) e.err = 1'b1;
    end
`ifdef CYC12_DTX_DETECT_EN
    if (pk < thr) begin e.dtx = 1'b1; e.harq = 2'b00; e.err = 1'b0; end
`endif
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1 && o_valid === 1'b1) begin
      n_valid++;
      total++;
      assert (sb.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_valid observed=1 expected=0");
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        if (e.chk_mcs) check("mcs", 32'(o_mcs), 32'(e.mcs));
        check("harq", 32'(o_harq), 32'(e.harq));
        check("peak", 32'(o_peak), 32'(e.peak));
        check("err",  32'(o_err),  32'(e.err));
        check("dtx",  32'(o_dtx),  32'(e.dtx));
      end
    end
  end

  task automatic push(input int base, input int nbits);
    sb.push_back(model(base, nbits, 32'(i_dtx_threshold)));
    n_push++;
  endtask

  task automatic start_sym(input int base, input int nbits);
    @(negedge clk);
    i_start      = 1'b1;
    i_base_alpha = 5'(base);
    i_nbits      = 2'(nbits);
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic feed(input int first, input int last, input bit gap);
    for (int k = first; k <= last; k++) begin
      if (gap && k != first) @(negedge clk);
      check("ready", 32'(o_ready), 32'd1);
      i_metric_valid = 1'b1;
      i_metric       = m[k][W-1:0];
      @(negedge clk);
      i_metric_valid = 1'b0;
    end
  endtask

  task automatic finish_sym();
    check("lat_resolve", 32'(o_valid), 32'd0);
    @(negedge clk);
    check("lat_done", 32'(o_valid), 32'd1);
    @(negedge clk);
    check("valid_one_cycle", 32'(o_valid), 32'd0);
  endtask

  task automatic fill(input int unsigned v);
    for (int k = 0; k < 12; k++) m[k] = v;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'(o_ready), 32'd0);
    check({tag, "_valid"}, 32'(o_valid), 32'd0);
    check({tag, "_mcs"},   32'(o_mcs),   32'd0);
    check({tag, "_harq"},  32'(o_harq),  32'd0);
    check({tag, "_peak"},  32'(o_peak),  32'd0);
    check({tag, "_err"},   32'(o_err),   32'd0);
    check({tag, "_dtx"},   32'(o_dtx),   32'd0);
  endtask

  initial begin
    rst_n = 1'b0; i_start = 1'b0; i_base_alpha = '0; i_nbits = 2'd1;
    i_metric_valid = 1'b0; i_metric = '0; i_dtx_threshold = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");

    // base 0, nbits 2, peak at k=3; start accepted on the first edge after release
    fill(10); m[3] = 1000;
    push(0, 2);
    rst_n = 1'b1; i_start = 1'b1; i_base_alpha = 5'd0; i_nbits = 2'd2;
    @(negedge clk);
    i_start = 1'b0;
    feed(0, 11, 1'b0);
    finish_sym();
    repeat (3) @(negedge clk);
    check("hold_mcs",  32'(o_mcs),  32'd3);
    check("hold_harq", 32'(o_harq), 32'd1);

    // base 10, nbits 1: wrap-around mcs
    fill(5); m[4] = 300;
    push(10, 1); start_sym(10, 1); feed(0, 11, 1'b0); finish_sym();
    fill(5); m[10] = 300;
    push(10, 1); start_sym(10, 1); feed(0, 11, 1'b0); finish_sym();

    // tie keeps lower k; then an off-grid peak
    fill(1); m[6] = 500; m[9] = 500;
    push(0, 2); start_sym(0, 2); feed(0, 11, 1'b0); finish_sym();
    fill(1); m[5] = 500;
    push(0, 2); start_sym(0, 2); feed(0, 11, 1'b0); finish_sym();

    // all-zero symbol: metric 0 still loads the peak
    fill(0);
    push(0, 1); start_sym(0, 1); feed(0, 11, 1'b0); finish_sym();

    // illegal configurations
    fill(2); m[0] = 90;
    push(0, 3);  start_sym(0, 3);  feed(0, 11, 1'b0); finish_sym();
    push(0, 0);  start_sym(0, 0);  feed(0, 11, 1'b0); finish_sym();
    push(13, 1); start_sym(13, 1); feed(0, 11, 1'b0); finish_sym();

    // gapped metrics, restart after the 7th: only the second symbol reports
    for (int k = 0; k < 12; k++) m[k] = $urandom_range(0, 999);
    start_sym(4, 1); feed(0, 6, 1'b1);
    for (int k = 0; k < 12; k++) m[k] = $urandom_range(0, 99);
    m[5] = 5000;
    push(2, 2); start_sym(2, 2); feed(0, 11, 1'b1); finish_sym();

    // reset after the 5th metric
    fill(7); m[1] = 800;
    start_sym(0, 1); feed(0, 4, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("no_valid_after_rst", 32'(n_valid), 32'(n_push));
    fill(20); m[10] = 650;
    push(1, 2); start_sym(1, 2); feed(0, 11, 1'b0); finish_sym();

    // low-energy symbol vs DTX threshold
    i_dtx_threshold = 16'd200;
    for (int k = 0; k < 12; k++) m[k] = 30 + 10 * k;
    m[11] = 150;
    push(5, 1); start_sym(5, 1); feed(0, 11, 1'b0); finish_sym();
    i_dtx_threshold = '0;

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    check("valid_count", 32'(n_valid), 32'(n_push));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
